sm83_zero_detect_seq: RTL and testbench
=======================================

Name: sm83_zero_detect_seq

Overview:
- Sequential, parametrised zero/all-ones detector for the SM83 ALU flag path.
- Consumes an ALU result as a stream of CHUNK_W-bit slices and produces one registered Z flag per operation:
  - 8-bit results arrive as two nibble slices.
  - 16-bit results arrive as four nibble slices.
- Sits between the nibble ALU datapath and the flag register.
- Replaces the fixed wide-NOR detect with a multi-cycle accumulator that adds a mode select, an abort, and a done handshake.

Parameters:
- CHUNK_W, 4: width of one result slice in bits; must be ≥ 1.
- MAX_CHUNKS, 4: maximum slices per operation; must be ≥ 1.
- CNT_W, $clog2(MAX_CHUNKS+1): width of the slice-count fields; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled in IDLE and DONE only.
- nchunks  input  CNT_W  slices in this operation; sampled with start.
- mode  input  1  0 = zero detect (all bits 0); 1 = all-ones detect (all bits 1); sampled with start.
- abort  input  1  cancel the current operation.
- chunk_valid  input  1  chunk carries a valid slice this cycle.
- chunk  input  CHUNK_W  result slice; least-significant slice first.
- busy  output  1  high in ACCUM.
- done  output  1  one-cycle pulse when the result is ready.
- z  output  1  flag result; holds until the next done.
- chunk_idx  output  CNT_W  number of slices accepted so far in the current operation.

Behaviour:
- Reset values: state = IDLE, busy = 0, done = 0, z = 0, chunk_idx = 0, internal accumulator = 1, latched count = 0, latched mode = 0.
- Reset is asynchronous and overrides everything, including mid-operation. No done is produced for an interrupted operation.
- Slice match:
  - mode 0: match = (chunk == 0).
  - mode 1: match = (chunk == all ones).
- State IDLE:
  - start = 1 latches nchunks and mode, sets acc = 1 and chunk_idx = 0.
  - If the clamped count is ≥ 1, go to ACCUM.
  - chunk_valid is ignored in IDLE.
- Count rules:
  - nchunks > MAX_CHUNKS is clamped to MAX_CHUNKS.
  - nchunks = 0 goes straight to DONE next cycle with z = 1 (empty result is vacuously zero or all-ones).
- State ACCUM:
  - Each cycle with chunk_valid = 1: acc <= acc & match, chunk_idx <= chunk_idx + 1.
  - Gaps with chunk_valid = 0 are allowed and leave state unchanged.
  - When the accepted slice makes chunk_idx equal the latched count, go to DONE.
  - start is ignored in ACCUM.
- State DONE (exactly one cycle):
  - done = 1, and z is updated to acc in the same cycle done rises. Both are registered outputs.
  - chunk_valid is ignored.
  - start = 1 in DONE begins a new operation as if in IDLE, giving back-to-back operations with no idle bubble. Otherwise go to IDLE.
- abort:
  - In ACCUM, abort = 1 returns to IDLE next cycle with chunk_idx = 0. z is unchanged and no done is produced.
  - abort has priority over a simultaneous chunk_valid.
  - abort in IDLE or DONE has no effect. In DONE, done still pulses and a simultaneous start is still honoured.
- Latency: z and done are valid in the cycle after the clock edge that accepts the last slice.
- busy is registered and equals (state == ACCUM).
- z changes only at reset or at the edge that enters DONE.
- Timing annotation:
  - z rise/fall delays use the same elmore-based sm83_timing helpers as the other cells.
  - Output load is a parameterless specparam default.
  - Timing annotation does not alter functional behaviour.

Test Plan:
- Reset, then start with nchunks = 2, mode = 0; slices 4'h0, 4'h0 on consecutive cycles. Expect busy = 1 for 2 cycles, then done pulse with z = 1 and chunk_idx = 2.
- nchunks = 4, mode = 0; slices 0, 0, 4'h8, 0 with a one-cycle chunk_valid gap between slices 2 and 3. Expect done exactly 1 cycle after the 4th slice, z = 0, no early done.
- mode = 1, nchunks = 2; slices F, F, giving z = 1. Then, issued with start during the DONE cycle, mode = 1, slices F, E. Expect a second done 2 accepted cycles later with z = 0, and no IDLE cycle between the two operations.
- Abort case: start with nchunks = 4, send 2 zero slices, assert abort together with a third slice. Expect IDLE next cycle, no done, z still 0 from the prior result, chunk_idx = 0.
- nchunks = 0 → done on the next cycle with z = 1. nchunks = 7 → clamped to 4: done after the 4th slice.
- Asynchronous reset asserted mid-ACCUM, between clock edges. Expect busy, done, z and chunk_idx all 0 immediately. No done after reset releases. Slices sent before the next start are ignored.

Source files
------------

// File: rtl/sm83_zero_detect_seq.sv
// ---------------------------------------------------------------------------
// sm83_zero_detect_seq
//
// Multi-cycle zero / all-ones detector for the SM83 ALU flag path. An ALU
// result arrives as a stream of CHUNK_W-bit slices, least-significant first
// (two nibbles for an 8-bit result, four for a 16-bit result). One registered
// Z flag is produced per operation together with a one-cycle done pulse.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   begin an operation (honoured in IDLE and DONE only)
//   nchunks      in   slices in this operation, sampled with start
//   mode         in   0 = zero detect, 1 = all-ones detect, sampled with start
//   abort        in   cancel the operation in progress (ACCUM only)
//   chunk_valid  in   chunk carries a valid slice this cycle
//   chunk        in   result slice
//   busy         out  high while accumulating slices
//   done         out  one-cycle pulse, z is valid alongside it
//   z            out  flag result, held until the next done
//   chunk_idx    out  slices accepted so far in the current operation
//   dbg_state    out  current FSM state encoding (IDLE=0, ACCUM=1, DONE=2)
//
// Handshake: a slice is consumed on every rising edge where the FSM is in
// ACCUM, chunk_valid is high and abort is low. There is no back-pressure;
// the producer may insert gaps by lowering chunk_valid.
// ---------------------------------------------------------------------------
module sm83_zero_detect_seq #(
    parameter int CHUNK_W    = 4,
    parameter int MAX_CHUNKS = 4,
    parameter int CNT_W      = $clog2(MAX_CHUNKS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   nchunks,
    input  logic               mode,
    input  logic               abort,
    input  logic               chunk_valid,
    input  logic [CHUNK_W-1:0] chunk,
    output logic               busy,
    output logic               done,
    output logic               z,
    output logic [CNT_W-1:0]   chunk_idx,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               z_q, z_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               match;
    logic [CNT_W-1:0]   ncl;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b1;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        z_d     = z_q;

        // Slice match uses the mode latched at start, not the live input.
        match = mode_q ? (chunk == {CHUNK_W{1'b1}}) : (chunk == {CHUNK_W{1'b0}});

        // Oversized requests are clamped to the largest supported result.
        ncl = (nchunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : nchunks;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d  = ncl;
                    mode_d = mode;
                    acc_d  = 1'b1;
                    idx_d  = '0;
                    if (ncl == '0) begin
                        // Empty result: vacuously matches in either mode.
                        state_d = ST_DONE;
                        z_d     = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (chunk_valid) begin
                    acc_d = acc_q & match;
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_d == cnt_q) begin
                        state_d = ST_DONE;
                        z_d     = acc_q & match;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCUM);
        done_d = (state_d == ST_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign z         = z_q;
    assign chunk_idx = idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sm83_zero_detect_seq.sv
// ---------------------------------------------------------------------------
// Testbench for sm83_zero_detect_seq. Directed vectors, one clock cycle per
// table row: inputs are driven, one rising edge is taken, then the registered
// outputs are compared against hand-computed values. An asynchronous reset
// sequence is written out by hand after the table.
// ---------------------------------------------------------------------------
module tb_sm83_zero_detect_seq;

  localparam int CHUNK_W    = 4;
  localparam int MAX_CHUNKS = 4;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);

  // ---------------- clock / reset ----------------
  logic               clk;
  logic               reset;
  logic               start;
  logic [CNT_W-1:0]   nchunks;
  logic               mode;
  logic               abort;
  logic               chunk_valid;
  logic [CHUNK_W-1:0] chunk;
  logic               busy;
  logic               done;
  logic               z;
  logic [CNT_W-1:0]   chunk_idx;
  logic [1:0]         dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sm83_zero_detect_seq #(
    .CHUNK_W    (CHUNK_W),
    .MAX_CHUNKS (MAX_CHUNKS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .nchunks     (nchunks),
    .mode        (mode),
    .abort       (abort),
    .chunk_valid (chunk_valid),
    .chunk       (chunk),
    .busy        (busy),
    .done        (done),
    .z           (z),
    .chunk_idx   (chunk_idx),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass;
  int n_total;

  task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic eb, input logic ed, input logic ez, input int ei);
    check("busy", row, {7'd0, busy}, {7'd0, eb});
    check("done", row, {7'd0, done}, {7'd0, ed});
    check("z", row, {7'd0, z}, {7'd0, ez});
    check("chunk_idx", row, 8'(chunk_idx), 8'(ei));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input int n, input logic md, input logic ab,
                       input logic cv, input logic [CHUNK_W-1:0] ch);
    start       = st;
    nchunks     = CNT_W'(n);
    mode        = md;
    abort       = ab;
    chunk_valid = cv;
    chunk       = ch;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic               st;
    int                 n;
    logic               md;
    logic               ab;
    logic               cv;
    logic [CHUNK_W-1:0] ch;
    logic               e_busy;
    logic               e_done;
    logic               e_z;
    int                 e_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input int n, input logic md, input logic ab,
                              input logic cv, input logic [3:0] ch,
                              input logic eb, input logic ed, input logic ez, input int ei);
    vec_t v;
    v.st = st; v.n = n; v.md = md; v.ab = ab; v.cv = cv; v.ch = ch;
    v.e_busy = eb; v.e_done = ed; v.e_z = ez; v.e_idx = ei;
    return v;
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;

    //             st n  md ab cv ch      busy done z idx
    // two zero nibbles, mode 0
    vecs.push_back(mk(1, 2, 0, 0, 0, 4'h0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 1, 2));
    // four slices with a gap, third slice non-zero
    vecs.push_back(mk(1, 4, 0, 0, 0, 4'h0,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h8,  1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h8,  1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  0, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 0, 4));
    // all-ones F,F then back-to-back F,E started in the DONE cycle
    vecs.push_back(mk(1, 2, 1, 0, 0, 4'h0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF,  0, 1, 1, 2));
    vecs.push_back(mk(1, 2, 1, 0, 1, 4'hF,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hE,  0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 0, 2));
    // abort together with the third slice, then abort in IDLE
    vecs.push_back(mk(1, 4, 0, 0, 0, 4'h0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'h0,  0, 0, 0, 0));
    // empty operation, then abort + start (n=7, clamped) in the DONE cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 4'h0,  0, 1, 1, 0));
    vecs.push_back(mk(1, 7, 0, 1, 0, 4'h0,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 4'h0,  1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0,  1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h1,  0, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 0, 4));

    // ---------------- reset ----------------
    drive(0, 0, 0, 0, 0, 4'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(-1, 0, 0, 0, 0);
    check("state", -1, {6'd0, dbg_state}, 8'd0);
    reset = 1'b0;
    step();
    check_outputs(-2, 0, 0, 0, 0);

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].n, vecs[i].md, vecs[i].ab, vecs[i].cv, vecs[i].ch);
      step();
      check_outputs(i, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_z, vecs[i].e_idx);
    end

    // ---------------- async reset mid-ACCUM ----------------
    drive(1, 0, 0, 0, 0, 4'h0);          // empty op leaves z = 1
    step();
    check_outputs(100, 0, 1, 1, 0);
    drive(1, 2, 0, 0, 0, 4'h0);
    step();
    drive(0, 0, 0, 0, 1, 4'h0);
    step();
    check_outputs(101, 1, 0, 1, 1);
    #2;
    reset = 1'b1;                        // between clock edges
    #1;
    check_outputs(102, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    // slices without a start must be ignored
    for (int k = 0; k < 3; k++) begin
      step();
      check_outputs(103 + k, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 4'h0);
    step();
    check_outputs(106, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
